// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, error, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, error, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring long divider: one quotient bit per cycle, optional
// two's-complement truncating mode, divide-by-zero reported via error.
module seq_divider #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ERR} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] dvnd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Operand magnitudes; |-2^(WIDTH-1)| still fits in WIDTH unsigned bits.
  always_comb begin
    sign_a  = SIGNED && bus.dividend[WIDTH-1];
    sign_b  = SIGNED && bus.divisor[WIDTH-1];
    mag_a   = sign_a ? WIDTH'(-bus.dividend) : bus.dividend;
    mag_b   = sign_b ? WIDTH'(-bus.divisor)  : bus.divisor;
    shifted = {rem, dvnd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = (bus.divisor == '0) ? ERR : RUN;
      RUN:  if (count == CW'(1)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      ERR:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered status outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      dvnd          <= '0;
      rem           <= '0;
      dvs           <= '0;
      count         <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      bus.ready     <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
    end else begin
      bus.ready <= (next_state == IDLE);
      bus.busy  <= (next_state == RUN) || (next_state == FIX);
      bus.done  <= (next_state == DONE) || (next_state == ERR);
      bus.error <= (next_state == ERR);
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvnd  <= mag_a;
            dvs   <= mag_b;
            rem   <= '0;
            count <= CW'(WIDTH);
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            if (bus.divisor == '0) begin
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend;
            end
          end
        end
        RUN: begin
          count <= count - CW'(1);
          dvnd  <= {dvnd[WIDTH-2:0], ~diff[WIDTH]};
          rem   <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
        FIX: begin
          bus.quotient  <= neg_q ? WIDTH'(-dvnd) : dvnd;
          bus.remainder <= neg_r ? WIDTH'(-rem)  : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed checks of seq_divider (8-bit unsigned, 8-bit signed,
// 16-bit unsigned) against an integer-arithmetic reference.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  int          sel;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] last_q [3];
  logic [15:0] last_r [3];
  int          last_done_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider_if #(.WIDTH(8))  if_u8 ();
  seq_divider_if #(.WIDTH(8))  if_s8 ();
  seq_divider_if #(.WIDTH(16)) if_u16 ();

  assign if_u8.start     = start && (sel == 0);
  assign if_u8.dividend  = dividend[7:0];
  assign if_u8.divisor   = divisor[7:0];
  assign if_s8.start     = start && (sel == 1);
  assign if_s8.dividend  = dividend[7:0];
  assign if_s8.divisor   = divisor[7:0];
  assign if_u16.start    = start && (sel == 2);
  assign if_u16.dividend = dividend;
  assign if_u16.divisor  = divisor;

  seq_divider #(.WIDTH(8),  .SIGNED(1'b0)) dut_u8  (.clk(clk), .reset(reset), .bus(if_u8.slave));
  seq_divider #(.WIDTH(8),  .SIGNED(1'b1)) dut_s8  (.clk(clk), .reset(reset), .bus(if_s8.slave));
  seq_divider #(.WIDTH(16), .SIGNED(1'b0)) dut_u16 (.clk(clk), .reset(reset), .bus(if_u16.slave));

  logic        o_ready, o_busy, o_done, o_error;
  logic [15:0] o_q, o_r;

  always_comb begin
    o_ready = if_u16.ready;
    o_busy  = if_u16.busy;
    o_done  = if_u16.done;
    o_error = if_u16.error;
    o_q     = if_u16.quotient;
    o_r     = if_u16.remainder;
    case (sel)
      0: begin
        o_ready = if_u8.ready;  o_busy = if_u8.busy;  o_done = if_u8.done;
        o_error = if_u8.error;  o_q = 16'(if_u8.quotient); o_r = 16'(if_u8.remainder);
      end
      1: begin
        o_ready = if_s8.ready;  o_busy = if_s8.busy;  o_done = if_s8.done;
        o_error = if_s8.error;  o_q = 16'(if_s8.quotient); o_r = 16'(if_s8.remainder);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 2) ? 16 : 8;
  endfunction

  // Reference: plain integer division; SV '/' and '%' truncate toward zero.
  function automatic void model(input int s, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r, output logic e);
    int     w    = width_of(s);
    longint mask = (longint'(1) << w) - 1;
    longint ai   = longint'(a) & mask;
    longint bi   = longint'(b) & mask;
    if (bi == 0) begin
      e = 1'b1;
      q = 16'(mask);
      r = 16'(ai);
    end else begin
      e = 1'b0;
      if (s == 1) begin
        if (((ai >> (w - 1)) & 1) == 1) ai = ai - (longint'(1) << w);
        if (((bi >> (w - 1)) & 1) == 1) bi = bi - (longint'(1) << w);
      end
      q = 16'((ai / bi) & mask);
      r = 16'((ai % bi) & mask);
    end
  endfunction

  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] eq, er;
    logic        ee;
    int          w, lat, waited;
    model(s, a, b, eq, er, ee);
    w = width_of(s);
    sel = s;
    waited = 0;
    while (!o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_start", 32'(o_ready), 32'd1);
    check("done_while_idle", 32'(o_done), 32'd0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    if (!ee) begin
      check("held_q_start", 32'(o_q), 32'(last_q[s]));
      check("held_r_start", 32'(o_r), 32'(last_r[s]));
      check("ready_low_run", 32'(o_ready), 32'd0);
      check("error_low_run", 32'(o_error), 32'd0);
    end
    while (!o_done && lat < 40) begin
      if (!ee) check("busy_run", 32'(o_busy), 32'd1);
      if (!ee && lat == w + 1) check("held_q_fix", 32'(o_q), 32'(last_q[s]));
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), ee ? 32'd1 : 32'(w + 2));
    check("quotient", 32'(o_q), 32'(eq));
    check("remainder", 32'(o_r), 32'(er));
    check("error", 32'(o_error), 32'(ee));
    check("busy_at_done", 32'(o_busy), 32'd0);
    last_q[s]     = eq;
    last_r[s]     = er;
    last_done_cyc = cyc;
  endtask

  initial begin
    int done_seen, d1;
    logic [15:0] a, b;
    int s, mode;
    reset = 1'b1; start = 1'b0; sel = 0; dividend = '0; divisor = '0;
    for (int i = 0; i < 3; i++) begin last_q[i] = '0; last_r[i] = '0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_busy",  32'(o_busy),  32'd0);
      check("rst_done",  32'(o_done),  32'd0);
      check("rst_error", 32'(o_error), 32'd0);
      check("rst_q",     32'(o_q),     32'd0);
      check("rst_r",     32'(o_r),     32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    run_op(0, 16'd100, 16'd7);
    run_op(0, 16'd55,  16'd0);
    run_op(0, 16'd255, 16'd1);
    run_op(0, 16'd3,   16'd200);
    run_op(1, 16'hF9,  16'h02);
    run_op(1, 16'h07,  16'hFE);
    run_op(1, 16'hF9,  16'hFE);
    run_op(1, 16'h80,  16'hFF);
    run_op(1, 16'h80,  16'h01);
    run_op(1, 16'h80,  16'h00);

    // Back-to-back at the earliest ready cycle.
    run_op(2, 16'd65535, 16'd255);
    d1 = last_done_cyc;
    run_op(2, 16'd1000, 16'd1001);
    check("issue_interval", 32'(last_done_cyc - d1), 32'd19);

    // Abort mid-RUN: ignored start in cycle 4, reset in cycle 6.
    sel = 0;
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dividend = 16'd9; divisor = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_busy",  32'(o_busy),  32'd0);
    check("abort_q",     32'(o_q),     32'd0);
    check("abort_r",     32'(o_r),     32'd0);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (o_done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    for (int i = 0; i < 3; i++) begin last_q[i] = '0; last_r[i] = '0; end
    run_op(0, 16'd9, 16'd3);

    // Reset and start together: start must be dropped.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_ready", 32'(o_ready), 32'd1);
    check("rst_start_busy",  32'(o_busy),  32'd0);
    @(negedge clk);
    check("rst_start_idle", 32'(o_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin last_q[i] = '0; last_r[i] = '0; end

    for (int i = 0; i < 60; i++) begin
      s    = $urandom_range(0, 2);
      mode = $urandom_range(0, 9);
      a    = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = (s == 2) ? 16'h8000 : 16'h0080;
      case (mode)
        0:       b = 16'h0000;
        1:       b = 16'hFFFF;
        2:       b = 16'($urandom_range(1, 3));
        default: b = 16'($urandom);
      endcase
      run_op(s, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
